// File: rtl/pd_fetch_seq_if.sv
// IR load interface between the predecode fetch sequencer and its environment
// (data bus, decoder, interrupt inputs, instruction register).
interface pd_fetch_seq_if;
  logic [7:0] DB_IN;
  logic       RDY;
  logic       INSTR_END;
  logic       n_NMI;
  logic       n_IRQ;
  logic       I_FLAG;
  logic [7:0] n_PD;
  logic       FETCH;
  logic       SYNC;
  logic       INJ;
  logic [1:0] INT_SRC;
  logic [2:0] T_CNT;

  modport master (
    input  DB_IN, RDY, INSTR_END, n_NMI, n_IRQ, I_FLAG,
    output n_PD, FETCH, SYNC, INJ, INT_SRC, T_CNT
  );

  modport slave (
    output DB_IN, RDY, INSTR_END, n_NMI, n_IRQ, I_FLAG,
    input  n_PD, FETCH, SYNC, INJ, INT_SRC, T_CNT
  );
endinterface

// File: rtl/pd_fetch_seq.sv
// Predecode fetch sequencer: latches the opcode byte in SYNC, strobes FETCH,
// injects BRK_OPCODE for reset/NMI/IRQ sequences and tracks the T-state.
module pd_fetch_seq #(
  parameter int unsigned RESET_CYCLES = 6,
  parameter logic [7:0]  BRK_OPCODE   = 8'h00
) (
  input logic            CLK,
  input logic            n_RES,
  pd_fetch_seq_if.master bus
);

  typedef enum logic [1:0] {ST_RST, ST_SYNC, ST_EXEC} state_t;
  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_IRQ   = 2'b01,
    SRC_NMI   = 2'b10,
    SRC_RESET = 2'b11
  } src_t;

  localparam logic [3:0] RESET_LOAD = 4'(RESET_CYCLES);

  state_t     state, state_nxt;
  src_t       pending, pending_nxt;
  src_t       int_src, int_src_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] pd, pd_nxt;
  logic [2:0] t_cnt, t_cnt_nxt;
  logic       fetch, fetch_nxt;
  logic       inj, inj_nxt;
  logic       nmi_latch, nmi_latch_nxt;
  logic       nmi_prev;
  logic       nmi_edge;

  assign nmi_edge = nmi_prev & ~bus.n_NMI;

  // NOTE: every variable gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    cnt_nxt       = cnt;
    pd_nxt        = pd;
    t_cnt_nxt     = t_cnt;
    fetch_nxt     = 1'b0;
    inj_nxt       = 1'b0;
    int_src_nxt   = SRC_NONE;
    nmi_latch_nxt = nmi_latch | nmi_edge;

    unique case (state)
      ST_RST: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = ST_SYNC;
          t_cnt_nxt = 3'd0;
        end
      end
      ST_SYNC: begin
        t_cnt_nxt = 3'd0;
        if (bus.RDY) begin
          pd_nxt      = (pending != SRC_NONE) ? BRK_OPCODE : bus.DB_IN;
          fetch_nxt   = 1'b1;
          inj_nxt     = (pending != SRC_NONE);
          int_src_nxt = pending;
          pending_nxt = SRC_NONE;
          state_nxt   = ST_EXEC;
          t_cnt_nxt   = 3'd1;
        end
      end
      ST_EXEC: begin
        if (bus.RDY) begin
          if (t_cnt != 3'd7) t_cnt_nxt = t_cnt + 3'd1;
          if (bus.INSTR_END) begin
            state_nxt = ST_SYNC;
            t_cnt_nxt = 3'd0;
            // An NMI edge arriving in this very cycle is taken by this boundary.
            if (nmi_latch | nmi_edge) begin
              pending_nxt   = SRC_NMI;
              nmi_latch_nxt = 1'b0;
            end else if (!bus.n_IRQ && !bus.I_FLAG) begin
              pending_nxt = SRC_IRQ;
            end else begin
              pending_nxt = SRC_NONE;
            end
          end
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values computed in the previous cycle.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state     <= ST_RST;
      pending   <= SRC_RESET;
      int_src   <= SRC_NONE;
      cnt       <= RESET_LOAD;
      pd        <= 8'h00;
      t_cnt     <= 3'd0;
      fetch     <= 1'b0;
      inj       <= 1'b0;
      nmi_latch <= 1'b0;
      nmi_prev  <= 1'b1;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      int_src   <= int_src_nxt;
      cnt       <= cnt_nxt;
      pd        <= pd_nxt;
      t_cnt     <= t_cnt_nxt;
      fetch     <= fetch_nxt;
      inj       <= inj_nxt;
      nmi_latch <= nmi_latch_nxt;
      nmi_prev  <= bus.n_NMI;
    end
  end

  assign bus.n_PD    = ~pd;
  assign bus.FETCH   = fetch;
  assign bus.SYNC    = (state == ST_SYNC);
  assign bus.INJ     = inj;
  assign bus.INT_SRC = int_src;
  assign bus.T_CNT   = t_cnt;

endmodule
